decode_issue: RTL
=================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage directly upstream of the 32-bit ALU. Accepts RV32I OP-IMM
//  and OP instructions over a valid/ready handshake, reads the 32x32 register
//  file, and builds the 6-bit ALU op plus both operands. Results are registered
//  and presented one cycle later. Also owns the register-file write-back port.
// PARAMETERS
//  XLEN      32  operand/register width; only 32 is supported
//  NUM_REGS  32  architectural registers; x0 is hardwired to zero
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  in_valid     in   1   in_instr is valid
//  in_ready     out  1   stage can accept in_instr this cycle
//  in_instr     in   32  raw instruction word
//  out_valid    out  1   out_* bundle is valid
//  out_ready    in   1   ALU/writeback side consumes the bundle this cycle
//  out_op       out  6   ALU op = {instr[30], instr[14:12], instr[5], 1'b1}
//  out_rv1      out  32  rs1 value
//  out_rv2      out  32  rs2 value (OP) or sign-extended instr[31:20] (OP-IMM)
//  out_rd       out  5   destination register instr[11:7]
//  out_we       out  1   result must be written back (legal && rd != 0)
//  out_illegal  out  1   opcode is neither 0010011 nor 0110011
//  wb_en        in   1   register-file write enable
//  wb_rd        in   5   write-back register index
//  wb_data      in   32  write-back data
// BEHAVIOUR
//  - Reset: out_valid=0; out_op/out_rv1/out_rv2/out_rd/out_we/out_illegal=0;
//    all registers=0; pending table cleared. Reset mid-handshake drops the bundle.
//  - in_ready = !out_valid || out_ready (gated by hazard when SCOREBOARD_EN).
//  - An instruction is accepted when in_valid && in_ready. The out_* bundle
//    loads on that edge, and out_valid=1 the next cycle (latency 1).
//  - out_valid falls when out_ready=1 with no new accept. Accept and drain in
//    the same cycle gives back-to-back issue at one instruction per cycle.
//  - The bundle is stable while out_valid && !out_ready.
//  - Write-back: on wb_en && wb_rd!=0, regs[wb_rd] <= wb_data. A write to x0
//    is ignored, and reads of x0 always return 0.
//  - Bypass: if wb_en && wb_rd==rs (rs!=0) in the accept cycle, the operand
//    takes wb_data, not the stale register value.
//  - Immediates: rv2 = {{20{instr[31]}}, instr[31:20]} for OP-IMM, including
//    shifts; the ALU uses only [4:0].
//  - Illegal opcode: out_illegal=1, out_op=6'b000000, out_we=0. Operands are
//    don't-care and are driven 0.
//  - OP with funct7 other than 0000000/0100000 is passed through unchanged.
//    The ALU default case returns 0.
// CONFIGURATION
//  SCOREBOARD_EN defined:
//   - Adds a 32-bit pending table. A bit is set on accept when out_we (rd!=0)
//     and cleared on wb_en for wb_rd.
//   - If clear and set hit the same index in the same cycle, set wins.
//   - Hazard = rs1 (or rs2, for OP only) pending and not bypassed this cycle.
//     On a hazard, in_ready=0 until it resolves.
//  SCOREBOARD_EN undefined: no interlock; in_ready ignores hazards, and the
//   producer must space dependent instructions.
// TESTING
//  1. Reset high mid-stream -> out_valid=0, out_* =0, x5 reads 0 after release.
//  2. wb x1=5, then addi x2,x1,-3 (0xFFD08113) -> out_op=000001 / 100001 form
//     per instr[30], rv1=5, rv2=0xFFFFFFFD, rd=2, we=1, one cycle after accept.
//  3. sub x3,x1,x2 with out_ready=0 for 3 cycles -> out_op=100011; bundle held
//     stable; in_ready=0; issue resumes the cycle out_ready=1.
//  4. srai x4,x1,4 -> out_op=110101, rv2[4:0]=4. Opcode 0000011 (load) ->
//     out_illegal=1, out_op=0, we=0.
//  5. wb_en x1=0x1234 in the same cycle addi x6,x1,0 is accepted -> rv1=0x1234
//     (bypass). addi x0,x0,1 -> we=0, rv1=0.
//  6. SCOREBOARD_EN: add x7,.. then add x8,x7,x7 -> second stalls (in_ready=0)
//     until wb_en x7, then issues with the bypassed value.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/issue stage for RV32I OP and OP-IMM: register file, write-back port, registered ALU bundle.
// Optional RAW interlock when SCOREBOARD_EN is defined; without it the producer must space dependents.
module decode_issue #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NUM_REGS = 32,
  localparam int unsigned RIDX_W   = $clog2(NUM_REGS),
  localparam int unsigned ILEN     = 32,
  localparam int unsigned OP_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [XLEN-1:0]   out_rv1,
  output logic [XLEN-1:0]   out_rv2,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_we,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data
);

  localparam int unsigned IMM_W      = 12;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;

  // Register file and output bundle state
  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic              valid_q,   valid_d;
  logic [OP_W-1:0]   op_q,      op_d;
  logic [XLEN-1:0]   rv1_q,     rv1_d;
  logic [XLEN-1:0]   rv2_q,     rv2_d;
  logic [RIDX_W-1:0] rd_q,      rd_d;
  logic              we_q,      we_d;
  logic              illegal_q, illegal_d;

  // Decode fields
  logic [6:0]        opcode_c;
  logic              is_op_c;
  logic              is_opimm_c;
  logic              legal_c;
  logic [RIDX_W-1:0] rs1_c;
  logic [RIDX_W-1:0] rs2_c;
  logic [RIDX_W-1:0] rd_c;
  logic [XLEN-1:0]   imm_c;
  logic [XLEN-1:0]   rs1_val_c;
  logic [XLEN-1:0]   rs2_val_c;
  logic              we_c;
  logic              hazard_c;
  logic              in_ready_c;
  logic              accept_c;

  always_comb begin
    opcode_c   = in_instr[6:0];
    is_op_c    = (opcode_c == OPC_OP);
    is_opimm_c = (opcode_c == OPC_OP_IMM);
    legal_c    = is_op_c || is_opimm_c;
    rd_c       = in_instr[11:7];
    rs1_c      = in_instr[19:15];
    rs2_c      = in_instr[24:20];
    imm_c      = {{(XLEN-IMM_W){in_instr[31]}}, in_instr[31:20]};
    we_c       = legal_c && (rd_c != '0);
  end

  // Operand read: x0 is zero, a same-cycle write-back forwards over the stale entry
  always_comb begin
    if (rs1_c == '0) begin
      rs1_val_c = '0;
    end else if (wb_en && (wb_rd == rs1_c)) begin
      rs1_val_c = wb_data;
    end else begin
      rs1_val_c = regs_q[rs1_c];
    end
    if (rs2_c == '0) begin
      rs2_val_c = '0;
    end else if (wb_en && (wb_rd == rs2_c)) begin
      rs2_val_c = wb_data;
    end else begin
      rs2_val_c = regs_q[rs2_c];
    end
  end

`ifdef SCOREBOARD_EN
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                rs1_busy_c;
  logic                rs2_busy_c;

  // A pending source blocks issue unless its write-back lands this very cycle
  always_comb begin
    rs1_busy_c = legal_c && pend_q[rs1_c] && !(wb_en && (wb_rd == rs1_c));
    rs2_busy_c = is_op_c && pend_q[rs2_c] && !(wb_en && (wb_rd == rs2_c));
    hazard_c   = rs1_busy_c || rs2_busy_c;
  end

  // Set after clear so a same-index issue keeps the entry pending
  always_comb begin
    pend_d = pend_q;
    if (wb_en) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (accept_c && we_c) begin
      pend_d[rd_c] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign hazard_c = 1'b0;
`endif

  assign in_ready_c = (!valid_q || out_ready) && !hazard_c;
  assign accept_c   = in_valid && in_ready_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_en && (wb_rd != '0)) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  // Bundle loads on accept, drains on out_ready, otherwise holds
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rv1_d     = rv1_q;
    rv2_d     = rv2_q;
    rd_d      = rd_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    if (accept_c) begin
      valid_d   = 1'b1;
      rd_d      = rd_c;
      we_d      = we_c;
      illegal_d = !legal_c;
      if (legal_c) begin
        op_d  = {in_instr[30], in_instr[14:12], in_instr[5], 1'b1};
        rv1_d = rs1_val_c;
        rv2_d = is_op_c ? rs2_val_c : imm_c;
      end else begin
        op_d  = '0;
        rv1_d = '0;
        rv2_d = '0;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      valid_q   <= 1'b0;
      op_q      <= '0;
      rv1_q     <= '0;
      rv2_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      valid_q   <= valid_d;
      op_q      <= op_d;
      rv1_q     <= rv1_d;
      rv2_q     <= rv2_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = valid_q;
  assign out_op      = op_q;
  assign out_rv1     = rv1_q;
  assign out_rv2     = rv2_q;
  assign out_rd      = rd_q;
  assign out_we      = we_q;
  assign out_illegal = illegal_q;

endmodule
